// File: rtl/min_max_pkg.sv
// Shared types for the min/max LED-bar decoder: bar/value widths, pattern class, FSM states.
package min_max_pkg;

   localparam int unsigned DEF_VALSIZE = 4;
   localparam int unsigned DEF_BAR_W   = 2 ** DEF_VALSIZE;

   typedef logic [DEF_BAR_W-1:0]   bar_t;
   typedef logic [DEF_VALSIZE-1:0] val_t;

   typedef enum logic [1:0] {
      CLS_BLANK   = 2'b00,
      CLS_BAR     = 2'b01,
      CLS_INVALID = 2'b10
   } class_e;

   typedef enum logic [2:0] {
      StIdle,
      StPhLo,
      StPhHi,
      StDecode,
      StDone
   } state_e;

endpackage

// File: rtl/min_max_bar_analyzer.sv
// Combinational bar analysis: lowest/highest lit index, single-run check, all-off flag.
module min_max_bar_analyzer #(
   parameter int unsigned VALSIZE = 4
) (
   input  logic [2**VALSIZE-1:0] bar,
   output logic [VALSIZE-1:0]    low,
   output logic [VALSIZE-1:0]    high,
   output logic                  contiguous,
   output logic                  empty
);

   localparam int unsigned BAR_W = 2 ** VALSIZE;

   logic [BAR_W-1:0] shifted;

   always_comb begin
      low  = '0;
      high = '0;
      for (int i = int'(BAR_W) - 1; i >= 0; i--) begin
         if (bar[i]) low = VALSIZE'(i);
      end
      for (int i = 0; i < int'(BAR_W); i++) begin
         if (bar[i]) high = VALSIZE'(i);
      end
   end

   assign empty   = (bar == '0);
   assign shifted = bar >> low;
   // After aligning the lowest lit bit to 0, a single run is a 2^n-1 mask.
   assign contiguous = !empty && ((shifted & (shifted + 1'b1)) == '0);

endmodule

// File: rtl/min_max_bar_decoder.sv
// Drives the display's osc input, samples the bar in both phases and recovers min/max/value.
module min_max_bar_decoder
   import min_max_pkg::*;
#(
   parameter int unsigned VALSIZE = 4,
   parameter int unsigned SETTLE  = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [2**VALSIZE-1:0] leds_i,
   output logic                  osc_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [1:0]            class_o,
   output logic [VALSIZE-1:0]    min_o,
   output logic [VALSIZE-1:0]    max_o,
   output logic [VALSIZE-1:0]    value_o
);

   localparam int unsigned BAR_W = 2 ** VALSIZE;
   localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BAR_W-1:0]   s0_q, s1_q;
   class_e             class_q, class_d;
   logic [VALSIZE-1:0] min_q, min_d, max_q, max_d, value_q, value_d;

   logic [VALSIZE-1:0] low0, high0, low1, high1;
   logic               cont0, empty0, cont1, empty1;

   min_max_bar_analyzer #(.VALSIZE(VALSIZE)) u_ana_s0 (
      .bar        (s0_q),
      .low        (low0),
      .high       (high0),
      .contiguous (cont0),
      .empty      (empty0)
   );

   min_max_bar_analyzer #(.VALSIZE(VALSIZE)) u_ana_s1 (
      .bar        (s1_q),
      .low        (low1),
      .high       (high1),
      .contiguous (cont1),
      .empty      (empty1)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StPhLo;
               cnt_d   = CNT_LOAD;
            end
         end
         StPhLo: begin
            if (cnt_q == '0) begin
               state_d = StPhHi;
               cnt_d   = CNT_LOAD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StPhHi: begin
            if (cnt_q == '0) state_d = StDecode;
            else             cnt_d   = cnt_q - 1'b1;
         end
         StDecode: state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      class_d = CLS_INVALID;
      min_d   = '0;
      max_d   = '0;
      value_d = '0;
      if (empty0 && empty1) begin
         class_d = CLS_BLANK;
      end else if (cont0 && cont1 && (low0 == low1) && ((s0_q & ~s1_q) == '0)) begin
         class_d = CLS_BAR;
         min_d   = low1;
         max_d   = high1;
         value_d = high0;
      end
   end

   // Capture on the last settle cycle of each phase; results load only in DECODE.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s0_q    <= '0;
         s1_q    <= '0;
         class_q <= CLS_BLANK;
         min_q   <= '0;
         max_q   <= '0;
         value_q <= '0;
      end else begin
         if (state_q == StPhLo && cnt_q == '0) s0_q <= leds_i;
         if (state_q == StPhHi && cnt_q == '0) s1_q <= leds_i;
         if (state_q == StDecode) begin
            class_q <= class_d;
            min_q   <= min_d;
            max_q   <= max_d;
            value_q <= value_d;
         end
      end
   end

   always_comb begin
      osc_o   = (state_q == StPhHi);
      busy_o  = (state_q != StIdle);
      done_o  = (state_q == StDone);
      class_o = class_q;
      min_o   = min_q;
      max_o   = max_q;
      value_o = value_q;
   end

endmodule

// File: tb/tb_min_max_bar_decoder.sv
// Directed bench: display model or fixed pattern pairs feed leds_i, results checked per scenario.
module tb_min_max_bar_decoder;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        start_i;
   logic [15:0] leds_i;
   logic        osc_o, busy_o, done_o;
   logic [1:0]  class_o;
   logic [3:0]  min_o, max_o, value_o;

   int vectors = 0;
   int miscompares = 0;

   // Display stimulus: either the min/max display model or a fixed (osc=0, osc=1) pattern pair.
   logic        use_model;
   int          m_min, m_max, m_val;
   logic [15:0] p0, p1;
   logic [31:0] busy_tr, osc_tr, done_tr;

   always #5 clk = ~clk;

   min_max_bar_decoder #(.VALSIZE(4), .SETTLE(2)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_ni),
      .start_i (start_i),
      .leds_i  (leds_i),
      .osc_o   (osc_o),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .class_o (class_o),
      .min_o   (min_o),
      .max_o   (max_o),
      .value_o (value_o)
   );

   function automatic logic [15:0] span(input int lo, input int hi);
      logic [15:0] r = '0;
      for (int i = 0; i < 16; i++) if (i >= lo && i <= hi) r[i] = 1'b1;
      return r;
   endfunction

   function automatic logic [15:0] model_leds(input logic osc);
      if (m_val < m_min || m_val > m_max) return 16'h0000;
      return osc ? span(m_min, m_max) : span(m_min, m_val);
   endfunction

   assign leds_i = use_model ? model_leds(osc_o) : (osc_o ? p1 : p0);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered at #1 after an edge (cycle 0); start_i follows mask bit k in cycle k.
   task automatic run(input logic [31:0] mask, input int n);
      busy_tr = '0;
      osc_tr  = '0;
      done_tr = '0;
      for (int k = 0; k < n; k++) begin
         start_i = mask[k];
         @(posedge clk);
         #1;
         busy_tr[k+1] = busy_o;
         osc_tr[k+1]  = osc_o;
         done_tr[k+1] = done_o;
      end
      start_i = 1'b0;
   endtask

   task automatic decode_check(input string tag, input logic [1:0] cls, input int mn,
                               input int mx, input int vl);
      run(32'h1, 8);
      check({tag, ".done"},  done_tr, 32'h40);
      check({tag, ".class"}, 32'(class_o), 32'(cls));
      check({tag, ".min"},   32'(min_o), 32'(mn));
      check({tag, ".max"},   32'(max_o), 32'(mx));
      check({tag, ".value"}, 32'(value_o), 32'(vl));
   endtask

   initial begin
      rst_ni    = 1'b0;
      start_i   = 1'b0;
      use_model = 1'b1;
      m_min = 3; m_max = 12; m_val = 8;
      p0 = '0;
      p1 = '0;
      #12;
      check("rst.busy",  32'(busy_o), 0);
      check("rst.osc",   32'(osc_o), 0);
      check("rst.done",  32'(done_o), 0);
      check("rst.class", 32'(class_o), 0);
      check("rst.min",   32'(min_o), 0);
      check("rst.max",   32'(max_o), 0);
      check("rst.value", 32'(value_o), 0);
      #10 rst_ni = 1'b1;
      @(posedge clk);
      #1;

      // Model min=3 max=12 value=8 with full timing trace.
      run(32'h1, 8);
      check("s1.busy",  busy_tr, 32'h7E);
      check("s1.osc",   osc_tr, 32'h18);
      check("s1.done",  done_tr, 32'h40);
      check("s1.class", 32'(class_o), 1);
      check("s1.min",   32'(min_o), 3);
      check("s1.max",   32'(max_o), 12);
      check("s1.value", 32'(value_o), 8);

      // Value outside [min,max] blanks the bar.
      m_min = 5; m_max = 10; m_val = 4;
      decode_check("s2a", 2'b00, 0, 0, 0);
      m_val = 11;
      decode_check("s2b", 2'b00, 0, 0, 0);

      // Static patterns.
      use_model = 1'b0;
      p0 = 16'h00F0; p1 = 16'h00F0;
      decode_check("s3a", 2'b01, 4, 7, 7);
      p0 = 16'hFFFF; p1 = 16'hFFFF;
      decode_check("s3b", 2'b01, 0, 15, 15);

      // Malformed patterns.
      p0 = 16'h0505; p1 = 16'h0505;
      decode_check("s4a", 2'b10, 0, 0, 0);
      p0 = 16'h00F0; p1 = 16'h0070;
      decode_check("s4b", 2'b10, 0, 0, 0);
      p0 = 16'h0000; p1 = 16'h0FF0;
      decode_check("s4c", 2'b10, 0, 0, 0);

      // start while busy is ignored, including in DONE.
      use_model = 1'b1;
      m_min = 3; m_max = 12; m_val = 8;
      run(32'h45, 12);
      check("s5a.busy", busy_tr, 32'h7E);
      check("s5a.done", done_tr, 32'h40);
      // start held high re-triggers on the first IDLE cycle.
      run(32'h3FFF, 16);
      check("s5b.busy", busy_tr, 32'h3F7E);
      check("s5b.osc",  osc_tr, 32'h0C18);
      check("s5b.done", done_tr, 32'h2040);
      check("s5b.value", 32'(value_o), 8);

      // Asynchronous reset in PH_HI aborts the decode.
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("s6.osc_pre", 32'(osc_o), 1);
      rst_ni = 1'b0;
      #1;
      check("s6.osc",   32'(osc_o), 0);
      check("s6.busy",  32'(busy_o), 0);
      check("s6.done",  32'(done_o), 0);
      check("s6.class", 32'(class_o), 0);
      check("s6.min",   32'(min_o), 0);
      check("s6.max",   32'(max_o), 0);
      check("s6.value", 32'(value_o), 0);
      @(posedge clk); #1;
      check("s6.done_hold", 32'(done_o), 0);
      @(posedge clk); #1;
      check("s6.busy_hold", 32'(busy_o), 0);
      rst_ni = 1'b1;
      @(posedge clk); #1;
      run(32'h1, 8);
      check("s6r.busy",  busy_tr, 32'h7E);
      check("s6r.done",  done_tr, 32'h40);
      check("s6r.class", 32'(class_o), 1);
      check("s6r.min",   32'(min_o), 3);
      check("s6r.max",   32'(max_o), 12);
      check("s6r.value", 32'(value_o), 8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
